// File: rtl/layer_out_collector.sv
// layer_out_collector
//   Tracks the node pipeline after a layer launch, snapshots the node outputs on the capture
//   edge, streams them out one word per valid/ready beat, and computes the arg-max class
//   index while the words go out.
module layer_out_collector #(
   parameter  int NUM_NODES = 8,
   parameter  int LATENCY   = 3,
   parameter  int DATA_W    = 16,
   localparam int IDX_W     = $clog2(NUM_NODES)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [32*NUM_NODES-1:0] n_bus,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_W-1:0]       out_data,
   output logic [IDX_W-1:0]        out_idx,
   output logic                    out_last,
   output logic                    busy,
   output logic                    class_valid,
   output logic [IDX_W-1:0]        class_idx,
   output logic                    drop_err
);

   localparam int             LAT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LATENCY - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);

   typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

   state_t             state;
   state_t             next_state;
   logic [LAT_W-1:0]   lat_cnt;
   logic [IDX_W-1:0]   idx;
   logic [DATA_W-1:0]  snap [NUM_NODES];
   logic [DATA_W-1:0]  max_val;
   logic [IDX_W-1:0]   max_idx;
   logic [DATA_W-1:0]  cur;
   logic               beat;
   logic               last_beat;
   logic               unused_bus;

   // Only the low DATA_W bits of each node word are streamed; the rest is deliberately ignored.
   assign unused_bus = ^n_bus;

   assign cur       = snap[idx];
   assign beat      = (state == SEND) && out_ready;
   assign last_beat = beat && (idx == LAST_IDX);

   // State register.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state logic; a start on the final beat launches the next frame directly.
   // NOTE: next_state gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = WAIT;
         WAIT:    if (lat_cnt == '0) next_state = SEND;
         SEND:    if (last_beat) next_state = start ? WAIT : IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Stream outputs; gated so they read zero whenever no word is offered.
   always_comb begin
      out_valid = (state == SEND);
      busy      = (state != IDLE);
      out_data  = out_valid ? cur : '0;
      out_idx   = out_valid ? idx : '0;
      out_last  = out_valid && (idx == LAST_IDX);
   end

   // Datapath: latency count, snapshot, beat index, running arg-max, result and error flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lat_cnt     <= '0;
         idx         <= '0;
         max_val     <= '0;
         max_idx     <= '0;
         class_idx   <= '0;
         class_valid <= 1'b0;
         drop_err    <= 1'b0;
         // NOTE: the snapshot is small and must read zero after reset, so it is reset explicitly.
         for (int k = 0; k < NUM_NODES; k++) snap[k] <= '0;
      end else begin
         class_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) lat_cnt <= LAT_INIT;
            end
            WAIT: begin
               if (start) drop_err <= 1'b1;
               if (lat_cnt == '0) begin
                  for (int k = 0; k < NUM_NODES; k++) snap[k] <= n_bus[32*k +: DATA_W];
                  idx <= '0;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            SEND: begin
               if (start && !last_beat) drop_err <= 1'b1;
               if (beat) begin
                  // First word seeds the max; later words replace it only when strictly larger.
                  if (idx == '0 || cur > max_val) begin
                     max_val <= cur;
                     max_idx <= idx;
                  end
                  if (idx == LAST_IDX) begin
                     class_idx   <= (cur > max_val) ? idx : max_idx;
                     class_valid <= 1'b1;
                     idx         <= '0;
                     if (start) lat_cnt <= LAT_INIT;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_layer_out_collector.sv
// tb_layer_out_collector
//   Directed scenarios for layer_out_collector: reset, plain and stalled frames, arg-max ties,
//   upper-bit masking, dropped starts, back-to-back launch and reset mid-frame.
module tb_layer_out_collector;

   localparam int N  = 8;
   localparam int DW = 16;
   localparam int IW = 3;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            start = 1'b0;
   logic [32*N-1:0] n_bus = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [DW-1:0]   out_data;
   logic [IW-1:0]   out_idx;
   logic            out_last;
   logic            busy;
   logic            class_valid;
   logic [IW-1:0]   class_idx;
   logic            drop_err;

   int   pass_cnt = 0;
   int   total_cnt = 0;
   bit   exp_drop = 1'b0;
   logic [31:0] nodes [N];

   layer_out_collector #(.NUM_NODES(N), .LATENCY(3), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset), .start(start), .n_bus(n_bus),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_idx(out_idx), .out_last(out_last), .busy(busy),
      .class_valid(class_valid), .class_idx(class_idx), .drop_err(drop_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [32*N-1:0] pack();
      logic [32*N-1:0] v;
      for (int k = 0; k < N; k++) v[32*k +: 32] = nodes[k];
      return v;
   endfunction

   task automatic set_nodes(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
      nodes[0] = a0; nodes[1] = a1; nodes[2] = a2; nodes[3] = a3;
      nodes[4] = a4; nodes[5] = a5; nodes[6] = a6; nodes[7] = a7;
      n_bus = pack();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      start = 1'b0;
      out_ready = 1'b0;
      exp_drop = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
   endtask

   // Runs one frame: launch (unless already launched), latency, all beats, result pulse.
   task automatic run_frame(input string name, input bit stall, input bit inject,
                            input bit start_on_last, input bit skip_start,
                            input logic [IW-1:0] exp_class);
      int k = 0;
      int cyc = 0;
      bit xfer;
      if (!skip_start) begin
         start = 1'b1;
         tick();
         start = 1'b0;
      end
      total_cnt++;
      if ({busy, out_valid} !== 2'b10)
         $display("FAIL %s launch: busy/valid=%b want 10", name, {busy, out_valid});
      else pass_cnt++;
      if (inject) begin
         start = 1'b1;
         exp_drop = 1'b1;
      end
      tick();
      start = 1'b0;
      total_cnt++;
      if ({out_valid, class_valid} !== 2'b00)
         $display("FAIL %s wait1: valid/class_valid=%b want 00", name, {out_valid, class_valid});
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({out_valid, drop_err} !== {1'b0, exp_drop})
         $display("FAIL %s wait2: valid/drop_err=%b want %b", name, {out_valid, drop_err},
                  {1'b0, exp_drop});
      else pass_cnt++;
      tick();
      // Node outputs move on after capture; the stream must not see it.
      n_bus = ~pack();
      while (k < N && cyc < 64) begin
         out_ready = stall ? (cyc % 3 == 0) : 1'b1;
         start = (inject && k == 4) || (start_on_last && k == N-1 && out_ready);
         total_cnt++;
         if ({out_valid, out_idx, out_data, out_last, class_valid} !==
             {1'b1, IW'(k), nodes[k][DW-1:0], (k == N-1), 1'b0})
            $display("FAIL %s beat%0d cyc%0d: v=%b idx=%0d data=%h last=%b cv=%b want v=1 idx=%0d data=%h last=%b cv=0",
                     name, k, cyc, out_valid, out_idx, out_data, out_last, class_valid,
                     k, nodes[k][DW-1:0], (k == N-1));
         else pass_cnt++;
         xfer = out_ready;
         tick();
         start = 1'b0;
         if (xfer) k++;
         cyc++;
      end
      out_ready = 1'b0;
      total_cnt++;
      if (k < N) $display("FAIL %s timeout: got %0d beats want %0d", name, k, N);
      else pass_cnt++;
      total_cnt++;
      if ({class_valid, class_idx, out_valid, busy, drop_err} !==
          {1'b1, exp_class, 1'b0, start_on_last, exp_drop})
         $display("FAIL %s result: cv=%b class=%0d v=%b busy=%b drop=%b want cv=1 class=%0d v=0 busy=%b drop=%b",
                  name, class_valid, class_idx, out_valid, busy, drop_err, exp_class,
                  start_on_last, exp_drop);
      else pass_cnt++;
      n_bus = pack();
   endtask

   task automatic test_reset();
      do_reset();
      total_cnt++;
      if ({out_valid, out_data, out_idx, out_last, busy, class_valid, class_idx, drop_err} !== '0)
         $display("FAIL reset_state: v=%b data=%h idx=%0d last=%b busy=%b cv=%b class=%0d drop=%b want all 0",
                  out_valid, out_data, out_idx, out_last, busy, class_valid, class_idx, drop_err);
      else pass_cnt++;
   endtask

   task automatic test_basic();
      set_nodes(32'h10, 32'h50, 32'h20, 32'h0, 32'h0, 32'h0, 32'h0, 32'h05);
      run_frame("basic", 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
      tick();
      tick();
      total_cnt++;
      if ({class_valid, class_idx, busy, out_valid} !== {1'b0, 3'd1, 1'b0, 1'b0})
         $display("FAIL basic_hold: cv=%b class=%0d busy=%b v=%b want cv=0 class=1 busy=0 v=0",
                  class_valid, class_idx, busy, out_valid);
      else pass_cnt++;
   endtask

   task automatic test_stall();
      set_nodes(32'h10, 32'h50, 32'h20, 32'h0, 32'h0, 32'h0, 32'h0, 32'h05);
      run_frame("stall", 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
      tick();
   endtask

   task automatic test_tie();
      set_nodes(32'h0, 32'h0, 32'hFFFF, 32'h0, 32'h0, 32'hFFFF, 32'h0, 32'h0);
      run_frame("tie", 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
      tick();
   endtask

   task automatic test_upper_bits();
      set_nodes(32'h100, 32'hFFFF_0002, 32'h3, 32'hABCD_1234,
                32'h0FFF, 32'h0, 32'h1233, 32'h1);
      run_frame("upper", 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
      tick();
   endtask

   task automatic test_last_max();
      set_nodes(32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8000);
      run_frame("last_max", 1'b1, 1'b0, 1'b0, 1'b0, 3'd7);
      tick();
   endtask

   task automatic test_drop();
      set_nodes(32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1, 32'h0);
      run_frame("drop", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
      tick();
      tick();
      total_cnt++;
      if (drop_err !== 1'b1) $display("FAIL drop_sticky: drop_err=%b want 1", drop_err);
      else pass_cnt++;
      do_reset();
      total_cnt++;
      if (drop_err !== 1'b0) $display("FAIL drop_clear: drop_err=%b want 0", drop_err);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      set_nodes(32'h10, 32'h50, 32'h20, 32'h0, 32'h0, 32'h0, 32'h0, 32'h05);
      run_frame("b2b_a", 1'b0, 1'b0, 1'b1, 1'b0, 3'd1);
      set_nodes(32'h1, 32'h2, 32'h3, 32'h4, 32'h900, 32'h6, 32'h7, 32'h8);
      run_frame("b2b_b", 1'b0, 1'b0, 1'b0, 1'b1, 3'd4);
      tick();
   endtask

   task automatic test_reset_mid();
      set_nodes(32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      out_ready = 1'b0;
      total_cnt++;
      if ({out_valid, out_idx, out_data} !== {1'b1, 3'd4, 16'h55})
         $display("FAIL mid_beat4: v=%b idx=%0d data=%h want v=1 idx=4 data=0055",
                  out_valid, out_idx, out_data);
      else pass_cnt++;
      reset = 1'b0;
      exp_drop = 1'b0;
      #1;
      total_cnt++;
      if ({out_valid, out_data, out_idx, out_last, busy, class_valid, class_idx} !== '0)
         $display("FAIL mid_reset: v=%b data=%h idx=%0d last=%b busy=%b cv=%b class=%0d want all 0",
                  out_valid, out_data, out_idx, out_last, busy, class_valid, class_idx);
      else pass_cnt++;
      tick();
      reset = 1'b1;
      tick();
      set_nodes(32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88);
      run_frame("after_reset", 1'b0, 1'b0, 1'b0, 1'b0, 3'd7);
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_tie();
      test_upper_bits();
      test_last_max();
      test_drop();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
